// File: rtl/pipe_stage_skid.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pipe_stage_skid
// Brief   : Elastic CPU pipeline-stage register with optional 2-entry skid.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic                w_out_valid;
  logic                w_out_fire;
  logic                w_in_fire;
  logic                w_load_main_in;
  logic                w_load_main_skid;
  logic                w_load_skid;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_out_fire  = w_out_valid & out_ready_i & ~stall_i;
  assign w_in_fire   = in_valid_i & in_ready_o;

  generate
    if (SKID != 0) begin : g_skid
      // Ready depends only on the state register, cutting the upstream ready path.
      assign in_ready_o = (r_state != ST_SKID);
    end else begin : g_no_skid
      assign in_ready_o = ~w_out_valid | (out_ready_i & ~stall_i);
    end
  endgenerate

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_FULL;
          w_load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire && (SKID != 0)) begin
          w_state_nxt = ST_SKID;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (w_out_fire) begin
          w_state_nxt      = ST_FULL;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush discards everything, including a same-cycle acceptance.
    if (flush_i) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main_data <= in_data_i;
        r_main_ctrl <= in_ctrl_i;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end else if (flush_i) begin
        r_main_ctrl <= '0;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data_i;
        r_skid_ctrl <= in_ctrl_i;
      end else if (w_load_main_skid || flush_i) begin
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end
    end
  end

  assign out_valid_o = w_out_valid;
  assign out_data_o  = r_main_data;
  // Empty slots present a zero control bundle so they never commit side effects.
  assign out_ctrl_o  = w_out_valid ? r_main_ctrl : '0;

  always_comb begin
    occupancy_o = 2'd0;
    case (r_state)
      ST_FULL: occupancy_o = 2'd1;
      ST_SKID: occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_pipe_stage_skid
// Brief   : Directed and randomised checks of pipe_stage_skid, SKID=1 and 0.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DW = 96;
  localparam int CW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          v1, rdy1, st1, fl1, or1, ov1;
  logic [DW-1:0] d1, od1;
  logic [CW-1:0] c1, oc1;
  logic [1:0]    occ1;
  logic          v0, rdy0, st0, fl0, or0, ov0;
  logic [DW-1:0] d0, od0;
  logic [CW-1:0] c0, oc0;
  logic [1:0]    occ0;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(v1), .in_ready_o(rdy1),
    .in_data_i(d1), .in_ctrl_i(c1), .stall_i(st1), .flush_i(fl1),
    .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1),
    .out_ctrl_o(oc1), .occupancy_o(occ1)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(v0), .in_ready_o(rdy0),
    .in_data_i(d0), .in_ctrl_i(c0), .stall_i(st0), .flush_i(fl0),
    .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0),
    .out_ctrl_o(oc0), .occupancy_o(occ0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    v1 = 0; d1 = '0; c1 = '0; st1 = 0; fl1 = 0; or1 = 0;
    v0 = 0; d0 = '0; c0 = '0; st0 = 0; fl0 = 0; or0 = 0;
  endtask

  task automatic test_reset;
    idle();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %0b want 0", ov1); end
    checks++; if (od1 !== '0) begin errors++; $display("FAIL reset_data1: got %h want 0", od1); end
    checks++; if (oc1 !== '0) begin errors++; $display("FAIL reset_ctrl1: got %h want 0", oc1); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL reset_occ1: got %0d want 0", occ1); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_ready1: got %0b want 1", rdy1); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %0b want 0", ov0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %0b want 1", rdy0); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] vals [3];
    vals = '{96'h11, 96'h22, 96'h33};
    idle();
    or1 = 1; or0 = 1; c1 = 8'hA5; c0 = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      v1 = 1; d1 = vals[i]; v0 = 1; d0 = vals[i];
      tick();
      checks++; if (ov1 !== 1'b1 || od1 !== vals[i]) begin errors++; $display("FAIL b2b_data1[%0d]: got v=%0b %h want v=1 %h", i, ov1, od1, vals[i]); end
      checks++; if (oc1 !== 8'hA5) begin errors++; $display("FAIL b2b_ctrl1[%0d]: got %h want a5", i, oc1); end
      checks++; if (occ1 !== 2'd1 || rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_occ1[%0d]: got occ=%0d rdy=%0b want occ=1 rdy=1", i, occ1, rdy1); end
      checks++; if (ov0 !== 1'b1 || od0 !== vals[i]) begin errors++; $display("FAIL b2b_data0[%0d]: got v=%0b %h want v=1 %h", i, ov0, od0, vals[i]); end
    end
    v1 = 0; v0 = 0;
    tick();
    checks++; if (ov1 !== 1'b0 || oc1 !== '0 || occ1 !== 2'd0) begin errors++; $display("FAIL b2b_drain1: got v=%0b ctrl=%h occ=%0d want 0 0 0", ov1, oc1, occ1); end
    checks++; if (ov0 !== 1'b0 || oc0 !== '0) begin errors++; $display("FAIL b2b_drain0: got v=%0b ctrl=%h want 0 0", ov0, oc0); end
  endtask

  task automatic test_skid_fill;
    idle();
    c1 = 8'hA5; v1 = 1; d1 = 96'h11;
    tick();
    checks++; if (od1 !== 96'h11 || occ1 !== 2'd1 || rdy1 !== 1'b1) begin errors++; $display("FAIL skid_first: got %h occ=%0d rdy=%0b want 11 1 1", od1, occ1, rdy1); end
    d1 = 96'h22;
    tick();
    checks++; if (od1 !== 96'h11 || occ1 !== 2'd2 || rdy1 !== 1'b0) begin errors++; $display("FAIL skid_full: got %h occ=%0d rdy=%0b want 11 2 0", od1, occ1, rdy1); end
    v1 = 0; or1 = 1;
    tick();
    checks++; if (ov1 !== 1'b1 || od1 !== 96'h22 || occ1 !== 2'd1 || rdy1 !== 1'b1) begin errors++; $display("FAIL skid_drain: got v=%0b %h occ=%0d rdy=%0b want 1 22 1 1", ov1, od1, occ1, rdy1); end
    tick();
    checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("FAIL skid_empty: got v=%0b occ=%0d want 0 0", ov1, occ1); end
  endtask

  task automatic test_flush;
    idle();
    c1 = 8'hA5; v1 = 1; d1 = 96'h11;
    tick();
    d1 = 96'h22;
    tick();
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", occ1); end
    fl1 = 1; d1 = 96'h33;
    tick();
    checks++; if (ov1 !== 1'b0 || oc1 !== '0) begin errors++; $display("FAIL flush_out: got v=%0b ctrl=%h want 0 0", ov1, oc1); end
    checks++; if (occ1 !== 2'd0 || rdy1 !== 1'b1) begin errors++; $display("FAIL flush_state: got occ=%0d rdy=%0b want 0 1", occ1, rdy1); end
    fl1 = 0; v1 = 0; or1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got v=%0b data=%h want v=0", i, ov1, od1); end
    end
  endtask

  task automatic test_stall_noskid;
    idle();
    c0 = 8'hA5; v0 = 1; d0 = 96'h44; or0 = 1;
    tick();
    checks++; if (ov0 !== 1'b1 || od0 !== 96'h44) begin errors++; $display("FAIL stall_load: got v=%0b %h want 1 44", ov0, od0); end
    st0 = 1; d0 = 96'h66;
    #1;
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL stall_ready_comb: got %0b want 0", rdy0); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ov0 !== 1'b1 || od0 !== 96'h44 || rdy0 !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: got v=%0b %h rdy=%0b want 1 44 0", i, ov0, od0, rdy0); end
    end
    st0 = 0;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b want 1", rdy0); end
    tick();
    checks++; if (ov0 !== 1'b1 || od0 !== 96'h66) begin errors++; $display("FAIL stall_next: got v=%0b %h want 1 66", ov0, od0); end
    v0 = 0;
    tick();
    checks++; if (ov0 !== 1'b0 || oc0 !== '0) begin errors++; $display("FAIL stall_drain: got v=%0b ctrl=%h want 0 0", ov0, oc0); end
  endtask

  task automatic test_async_reset;
    idle();
    c1 = 8'hA5; v1 = 1; d1 = 96'h11;
    tick();
    d1 = 96'h22;
    tick();
    v1 = 0;
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL areset_pre_occ: got %0d want 2", occ1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ov1 !== 1'b0 || od1 !== '0 || oc1 !== '0) begin errors++; $display("FAIL areset_out: got v=%0b %h ctrl=%h want 0 0 0", ov1, od1, oc1); end
    checks++; if (occ1 !== 2'd0 || rdy1 !== 1'b1) begin errors++; $display("FAIL areset_state: got occ=%0d rdy=%0b want 0 1", occ1, rdy1); end
    v1 = 1; d1 = 96'h55; or1 = 1;
    rst_n = 1'b1;
    tick();
    checks++; if (ov1 !== 1'b1 || od1 !== 96'h55 || oc1 !== 8'hA5) begin errors++; $display("FAIL areset_first: got v=%0b %h ctrl=%h want 1 55 a5", ov1, od1, oc1); end
    v1 = 0;
    tick();
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL areset_drain: got v=%0b want 0", ov1); end
  endtask

  task automatic test_random;
    ent_t q1[$];
    ent_t q0[$];
    ent_t e;
    logic exp_r1, exp_r0, of1, of0;
    idle();
    fl1 = 1; fl0 = 1;
    tick();
    fl1 = 0; fl0 = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks++; if (ov1 !== (q1.size() != 0) || occ1 !== 2'(q1.size())) begin errors++; $display("FAIL rnd_state1 cyc %0d: got v=%0b occ=%0d want occ=%0d", cyc, ov1, occ1, q1.size()); end
      if (q1.size() != 0) begin
        checks++; if (od1 !== q1[0].d || oc1 !== q1[0].c) begin errors++; $display("FAIL rnd_data1 cyc %0d: got %h/%h want %h/%h", cyc, od1, oc1, q1[0].d, q1[0].c); end
      end else begin
        checks++; if (oc1 !== '0) begin errors++; $display("FAIL rnd_ctrl_idle1 cyc %0d: got %h want 0", cyc, oc1); end
      end
      checks++; if (ov0 !== (q0.size() != 0) || occ0 !== 2'(q0.size())) begin errors++; $display("FAIL rnd_state0 cyc %0d: got v=%0b occ=%0d want occ=%0d", cyc, ov0, occ0, q0.size()); end
      if (q0.size() != 0) begin
        checks++; if (od0 !== q0[0].d || oc0 !== q0[0].c) begin errors++; $display("FAIL rnd_data0 cyc %0d: got %h/%h want %h/%h", cyc, od0, oc0, q0[0].d, q0[0].c); end
      end else begin
        checks++; if (oc0 !== '0) begin errors++; $display("FAIL rnd_ctrl_idle0 cyc %0d: got %h want 0", cyc, oc0); end
      end

      v1 = ($urandom_range(2, 0) != 0);
      d1 = v1 ? {$urandom(), $urandom(), $urandom()} : 'x;
      c1 = v1 ? 8'($urandom()) : 'x;
      or1 = ($urandom_range(2, 0) != 0);
      st1 = ($urandom_range(3, 0) == 0);
      fl1 = ($urandom_range(31, 0) == 0);
      v0 = ($urandom_range(2, 0) != 0);
      d0 = v0 ? {$urandom(), $urandom(), $urandom()} : 'x;
      c0 = v0 ? 8'($urandom()) : 'x;
      or0 = ($urandom_range(2, 0) != 0);
      st0 = ($urandom_range(3, 0) == 0);
      fl0 = ($urandom_range(31, 0) == 0);
      #1;
      exp_r1 = (q1.size() < 2);
      exp_r0 = (q0.size() == 0) || (or0 && !st0);
      checks++; if (rdy1 !== exp_r1) begin errors++; $display("FAIL rnd_ready1 cyc %0d: got %0b want %0b", cyc, rdy1, exp_r1); end
      checks++; if (rdy0 !== exp_r0) begin errors++; $display("FAIL rnd_ready0 cyc %0d: got %0b want %0b", cyc, rdy0, exp_r0); end

      of1 = (q1.size() != 0) && or1 && !st1;
      if (of1) void'(q1.pop_front());
      if (fl1) q1.delete();
      else if (v1 && exp_r1) begin e.d = d1; e.c = c1; q1.push_back(e); end
      of0 = (q0.size() != 0) && or0 && !st0;
      if (of0) void'(q0.pop_front());
      if (fl0) q0.delete();
      else if (v0 && exp_r0) begin e.d = d0; e.c = c0; q0.push_back(e); end
      tick();
    end
    idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_skid_fill();
    test_flush();
    test_stall_noskid();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
